// File: rtl/loader_pkg.sv
// Shared definitions for the UART boot loader.
// Contents: loader FSM state encoding, default frame sync byte, byte counts of
// the ADDR / LEN / DATA fields, and the memory write request record.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [2:0] ADDR_BYTES = 3'd4;
    localparam logic [2:0] LEN_BYTES  = 3'd2;
    localparam logic [2:0] WORD_BYTES = 3'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_req_t;

endpackage

// File: rtl/loader_byte_asm.sv
// Little-endian byte-to-word assembler shared by the ADDR, LEN and DATA fields.
// The first byte of a field lands in bits [7:0]. word_o is the field value
// including the byte currently presented, so the parent can act on the final
// byte in the same cycle it arrives. The counter and word self-clear after the
// last byte of a field.
// Ports:
//   clk, rst    clock, synchronous active-low reset
//   clr_i       restart field assembly (frame resync)
//   en_i        byte_i is valid and belongs to the current field
//   byte_i      incoming byte
//   nbytes_i    field length in bytes (1..4)
//   word_o      assembled value including byte_i
//   last_o      byte_i completes the field this cycle
module loader_byte_asm
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    input  logic [2:0]  nbytes_i,
    output logic [31:0] word_o,
    output logic        last_o
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    always_comb begin
        word_o = word_q;
        word_o[{cnt_q, 3'b000} +: 8] = byte_i;
        last_o = en_i && ({1'b0, cnt_q} == (nbytes_i - 3'd1));
    end

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (en_i) begin
            if (last_o) begin
                word_q <= '0;
                cnt_q  <= '0;
            end else begin
                word_q <= word_o;
                cnt_q  <= cnt_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses SYNC | ADDR(4) | LEN(2) | DATA(4*N) | CSUM(1) from
// the UART receive byte stream, writes each 32-bit word to the memory bus and
// keeps the CPU in reset until a complete image with a good checksum is in.
// Optional feature macro: LOADER_TIMEOUT_EN (inter-byte timeout -> ERR).
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   rx_valid, rx_data   one-cycle received-byte strobe and byte
//   mem_we              write request, held until mem_ack
//   mem_addr, mem_wdata word address / data of the pending write
//   mem_ack             memory accepted the write this cycle
//   cpu_hold            1 keeps the CPU in reset
//   done                sticky: image loaded, checksum good
//   err                 sticky until next SYNC: frame error
module uart_boot_loader
    import loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    state_t      st_q;
    state_t      take;      // state that owns an incoming byte this cycle
    logic [31:0] addr_q;
    logic [15:0] rem_q;
    logic [7:0]  acc_q;
    wr_req_t     req_q;
    logic        mem_we_q;
    logic        done_q;
    logic        err_q;
    logic        hold_q;

    logic        asm_en;
    logic        asm_clr;
    logic [2:0]  asm_nb;
    logic [31:0] asm_word;
    logic        asm_last;

    // A byte landing in the same cycle as the write ack is not an overrun:
    // it belongs to whatever state follows the completed write.
    always_comb begin
        take = st_q;
        if (st_q == WRITE && mem_ack)
            take = (rem_q == 16'd1) ? CSUM : DATA;
        asm_en  = rx_valid && (take inside {ADDR, LEN, DATA});
        asm_clr = rx_valid && (take inside {IDLE, ERR}) && (rx_data == SYNC_BYTE);
        asm_nb  = (take == ADDR) ? ADDR_BYTES :
                  (take == LEN)  ? LEN_BYTES  : WORD_BYTES;
    end

    loader_byte_asm u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (asm_clr),
        .en_i     (asm_en),
        .byte_i   (rx_data),
        .nbytes_i (asm_nb),
        .word_o   (asm_word),
        .last_o   (asm_last)
    );

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] tmo_q;
`else
    logic tmo_unused;
    assign tmo_unused = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q     <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            req_q    <= '0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            if (st_q == WRITE && mem_ack) begin
                mem_we_q <= 1'b0;
                addr_q   <= addr_q + 32'd4;
                rem_q    <= rem_q - 16'd1;
                st_q     <= take;
            end

            if (asm_en)
                acc_q <= acc_q + rx_data;

            if (rx_valid) begin
                case (take)
                    IDLE, ERR: begin
                        if (rx_data == SYNC_BYTE) begin
                            st_q  <= ADDR;
                            acc_q <= '0;
                            err_q <= 1'b0;
                        end
                    end
                    ADDR: begin
                        if (asm_last) begin
                            addr_q <= asm_word;
                            if (asm_word[1:0] != 2'b00) begin
                                st_q  <= ERR;
                                err_q <= 1'b1;
                            end else begin
                                st_q <= LEN;
                            end
                        end
                    end
                    LEN: begin
                        if (asm_last) begin
                            rem_q <= asm_word[15:0];
                            st_q  <= (asm_word[15:0] == 16'd0) ? CSUM : DATA;
                        end
                    end
                    DATA: begin
                        if (asm_last) begin
                            req_q    <= '{addr: addr_q, data: asm_word};
                            mem_we_q <= 1'b1;
                            st_q     <= WRITE;
                        end
                    end
                    WRITE: begin
                        // Byte overran an unacked write: abandon it.
                        st_q     <= ERR;
                        err_q    <= 1'b1;
                        mem_we_q <= 1'b0;
                    end
                    CSUM: begin
                        if (8'(acc_q + rx_data) == 8'h00) begin
                            st_q   <= DONE;
                            done_q <= 1'b1;
                            hold_q <= 1'b0;
                        end else begin
                            st_q  <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

`ifdef LOADER_TIMEOUT_EN
            // WRITE holds the count; bus stalls are not a line timeout.
            if (rx_valid || (st_q inside {IDLE, DONE, ERR})) begin
                tmo_q <= '0;
            end else if (st_q != WRITE) begin
                tmo_q <= tmo_q + 32'd1;
                if (tmo_q + 32'd1 == TIMEOUT_CYCLES) begin
                    st_q     <= ERR;
                    err_q    <= 1'b1;
                    mem_we_q <= 1'b0;
                end
            end
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.data;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
